// File: rtl/seq_player_pkg.sv
// Shared types and widths for the sequence player: FSM encoding, bus widths
// common with the address counter and ROM, and the tick counter sizing helper.
package seq_player_pkg;

    localparam int SP_DATA = 4;
    localparam int SP_LED  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SHOW = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Counter must hold the larger reload value; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seq_player_if.sv
// Control, timebase and ROM signals between the game controller and the player.
interface seq_player_if;
    import seq_player_pkg::*;

    logic               start;
    logic               clear;
    logic [SP_DATA-1:0] round;
    logic               tick;
    logic [SP_LED-1:0]  rom_data;
    logic [SP_DATA-1:0] addr;
    logic [SP_LED-1:0]  leds;
    logic               busy;
    logic               done;

    modport master (
        output start, clear, round, tick, rom_data,
        input  addr, leds, busy, done
    );

    modport slave (
        input  start, clear, round, tick, rom_data,
        output addr, leds, busy, done
    );

endinterface

// File: rtl/seq_player_tick_timer.sv
// Tick-strobe down-counter: reloaded on phase entry, expires on the tick that
// arrives while the count sits at zero.
module seq_player_tick_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         R_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] cnt;

    assign expire = en & tick & (cnt == '0);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/seq_player.sv
// Plays ROM entries 0..round on the LEDs, each lit for P_HOLD ticks and
// followed by P_GAP dark ticks, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | ROM address settled, data captured on exit
//   SHOW  | element lit, counting hold ticks
//   GAP   | LEDs dark, counting gap ticks
//   FIN   | done high for this cycle, busy drops on exit
module seq_player
    import seq_player_pkg::*;
#(
    parameter int P_HOLD = 8,
    parameter int P_GAP  = 4
) (
    input  logic         clk,
    input  logic         R_n,
    seq_player_if.slave  bus
);

    localparam int            TW      = cnt_width(P_HOLD, P_GAP);
    localparam logic [TW-1:0] HOLD_LD = TW'(P_HOLD - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(P_GAP - 1);

    state_t             state;
    logic [SP_DATA-1:0] round_q;
    logic [SP_DATA-1:0] addr_q;
    logic [SP_LED-1:0]  leds_q;
    logic               busy_q;
    logic               done_q;

    logic               t_load;
    logic [TW-1:0]      t_load_val;
    logic               t_en;
    logic               t_expire;

    // Reload on entry to SHOW (from LOAD) and to GAP (on hold expiry); ticks
    // on those entry edges are therefore never counted.
    assign t_load     = (state == ST_LOAD) | ((state == ST_SHOW) & t_expire);
    assign t_load_val = (state == ST_LOAD) ? HOLD_LD : GAP_LD;
    assign t_en       = (state == ST_SHOW) | (state == ST_GAP);

    seq_player_tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .R_n      (R_n),
        .clr      (bus.clear),
        .load     (t_load),
        .load_val (t_load_val),
        .en       (t_en),
        .tick     (bus.tick),
        .expire   (t_expire)
    );

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state   <= ST_IDLE;
            round_q <= '0;
            addr_q  <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.clear) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            leds_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        round_q <= bus.round;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    leds_q <= bus.rom_data;
                    state  <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (t_expire) begin
                        leds_q <= '0;
                        state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Compare before increment so the last address never wraps.
                    if (t_expire) begin
                        if (addr_q == round_q) begin
                            done_q <= 1'b1;
                            state  <= ST_FIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_FIN: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr = addr_q;
    assign bus.leds = leds_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
